// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared geometry, control codes and state type for the VGA text buffer
package vga_text_pkg;
    localparam int ROW_CNT   = 3;
    localparam int ROW_SIZE  = 10;
    localparam int CNT_W     = 4;
    localparam int ROW_IDX_W = 2;

    localparam logic [7:0] BLANK_CODE = 8'd0;
    localparam logic [7:0] BS_CODE    = 8'hF0;
    localparam logic [7:0] NL_CODE    = 8'hF1;
    localparam logic [7:0] CLR_CODE   = 8'hF2;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROW_CNT - 1);
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(ROW_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCROLL,
        S_CLEAR
    } state_t;
endpackage

// File: rtl/vga_text_buffer.sv
// rtl/vga_text_buffer.sv - editable letter grid with frame-synchronous commit to the display registers
module vga_text_buffer
    import vga_text_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [7:0]           i_code,
    output logic                 o_ready,
    input  logic                 i_frame_start,
    output logic [CNT_W-1:0]     o_letter_cnt [0:ROW_CNT-1],
    output logic [7:0]           o_letters    [0:ROW_CNT-1][0:ROW_SIZE-1],
    output logic [ROW_IDX_W-1:0] o_cursor_row,
    output logic [CNT_W-1:0]     o_cursor_col
);
    state_t state, state_nxt;

    logic [7:0]           wk_letters [0:ROW_CNT-1][0:ROW_SIZE-1];
    logic [CNT_W-1:0]     wk_cnt     [0:ROW_CNT-1];
    logic [ROW_IDX_W-1:0] cur_row, row_idx, row_inc, row_dec;
    logic [CNT_W-1:0]     cur_cnt, cnt_dec;
    logic [7:0]           held_code;
    logic                 held_vld;
    logic                 commit_pending;
    logic                 accept, is_bs, is_nl, is_clr, is_print;

    assign o_ready  = (state == S_IDLE);
    assign accept   = i_valid && o_ready;
    assign is_bs    = (i_code == BS_CODE);
    assign is_nl    = (i_code == NL_CODE);
    assign is_clr   = (i_code == CLR_CODE);
    assign is_print = !(is_bs || is_nl || is_clr);

    assign cur_cnt  = wk_cnt[cur_row];
    assign cnt_dec  = cur_cnt - 1'b1;
    assign row_inc  = cur_row + 1'b1;
    assign row_dec  = cur_row - 1'b1;

    assign o_cursor_row = cur_row;
    assign o_cursor_col = cur_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_clr)
                        state_nxt = S_CLEAR;
                    else if (is_nl && cur_row == LAST_ROW)
                        state_nxt = S_SCROLL;
                    else if (is_print && cur_cnt == FULL_CNT && cur_row == LAST_ROW)
                        state_nxt = S_SCROLL;
                end
            end
            S_SCROLL, S_CLEAR: begin
                if (row_idx == LAST_ROW) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working buffer: edits in S_IDLE, one row per cycle in S_SCROLL/S_CLEAR
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                wk_cnt[r] <= '0;
                for (int j = 0; j < ROW_SIZE; j++) wk_letters[r][j] <= BLANK_CODE;
            end
            cur_row   <= '0;
            row_idx   <= '0;
            held_code <= BLANK_CODE;
            held_vld  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    row_idx <= '0;
                    if (accept) begin
                        if (is_print) begin
                            if (cur_cnt != FULL_CNT) begin
                                wk_letters[cur_row][cur_cnt] <= i_code;
                                wk_cnt[cur_row]              <= cur_cnt + 1'b1;
                            end else if (cur_row != LAST_ROW) begin
                                cur_row                <= row_inc;
                                wk_letters[row_inc][0] <= i_code;
                                wk_cnt[row_inc]        <= CNT_W'(1);
                            end else begin
                                held_code <= i_code;
                                held_vld  <= 1'b1;
                            end
                        end else if (is_nl) begin
                            if (cur_row != LAST_ROW) cur_row <= row_inc;
                            else                     held_vld <= 1'b0;
                        end else if (is_bs) begin
                            if (cur_cnt != '0) begin
                                wk_cnt[cur_row]              <= cnt_dec;
                                wk_letters[cur_row][cnt_dec] <= BLANK_CODE;
                            end else if (cur_row != '0) begin
                                cur_row <= row_dec;
                            end
                        end
                    end
                end
                S_SCROLL: begin
                    if (row_idx == LAST_ROW) begin
                        for (int j = 0; j < ROW_SIZE; j++) wk_letters[ROW_CNT-1][j] <= BLANK_CODE;
                        if (held_vld) begin
                            wk_letters[ROW_CNT-1][0] <= held_code;
                            wk_cnt[ROW_CNT-1]        <= CNT_W'(1);
                        end else begin
                            wk_cnt[ROW_CNT-1] <= '0;
                        end
                        held_vld <= 1'b0;
                        cur_row  <= LAST_ROW;
                        row_idx  <= '0;
                    end else begin
                        for (int r = 0; r < ROW_CNT - 1; r++) begin
                            if (row_idx == ROW_IDX_W'(r)) begin
                                wk_cnt[r] <= wk_cnt[r+1];
                                for (int j = 0; j < ROW_SIZE; j++) wk_letters[r][j] <= wk_letters[r+1][j];
                            end
                        end
                        row_idx <= row_idx + 1'b1;
                    end
                end
                S_CLEAR: begin
                    for (int r = 0; r < ROW_CNT; r++) begin
                        if (row_idx == ROW_IDX_W'(r)) begin
                            wk_cnt[r] <= '0;
                            for (int j = 0; j < ROW_SIZE; j++) wk_letters[r][j] <= BLANK_CODE;
                        end
                    end
                    if (row_idx == LAST_ROW) begin
                        cur_row <= '0;
                        row_idx <= '0;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                default: row_idx <= '0;
            endcase
        end
    end

    // Commit samples the pre-edge working copy, so a code accepted this cycle lands next frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                o_letter_cnt[r] <= '0;
                for (int j = 0; j < ROW_SIZE; j++) o_letters[r][j] <= BLANK_CODE;
            end
            commit_pending <= 1'b0;
        end else if (state == S_IDLE && (commit_pending || i_frame_start)) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                o_letter_cnt[r] <= wk_cnt[r];
                for (int j = 0; j < ROW_SIZE; j++) o_letters[r][j] <= wk_letters[r][j];
            end
            commit_pending <= 1'b0;
        end else if (i_frame_start) begin
            commit_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_text_buffer.sv
// tb/tb_vga_text_buffer.sv - directed self-checking bench for vga_text_buffer
module tb_vga_text_buffer;
    import vga_text_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic [7:0]           i_code = 8'd0;
    logic                 o_ready;
    logic                 i_frame_start = 1'b0;
    logic [3:0]           o_letter_cnt [0:ROW_CNT-1];
    logic [7:0]           o_letters    [0:ROW_CNT-1][0:ROW_SIZE-1];
    logic [1:0]           o_cursor_row;
    logic [3:0]           o_cursor_col;

    logic [7:0] exp_l [0:ROW_CNT-1][0:ROW_SIZE-1];
    logic [3:0] exp_c [0:ROW_CNT-1];

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    vga_text_buffer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_code        (i_code),
        .o_ready       (o_ready),
        .i_frame_start (i_frame_start),
        .o_letter_cnt  (o_letter_cnt),
        .o_letters     (o_letters),
        .o_cursor_row  (o_cursor_row),
        .o_cursor_col  (o_cursor_col)
    );

    task automatic do_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_code = 8'd0; i_frame_start = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic clear_exp;
        for (int r = 0; r < ROW_CNT; r++) begin
            exp_c[r] = 4'd0;
            for (int j = 0; j < ROW_SIZE; j++) exp_l[r][j] = 8'd0;
        end
    endtask

    task automatic send(input logic [7:0] code);
        int n;
        n = 0;
        while (!o_ready && n < 20) begin @(negedge i_clk); n++; end
        if (!o_ready) begin
            total++; bad++;
            $display("FAIL send_ready_timeout code=%0d got ready=%b want 1", code, o_ready);
        end
        i_valid = 1'b1; i_code = code;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic frame_pulse;
        i_frame_start = 1'b1;
        @(negedge i_clk);
        i_frame_start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd0) begin bad++;
            $display("FAIL reset_cursor got=(%0d,%0d) want=(0,0)", o_cursor_row, o_cursor_col); end
        clear_exp();
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== exp_c[r]) begin bad++;
                $display("FAIL reset_cnt row%0d got=%0d want=%0d", r, o_letter_cnt[r], exp_c[r]); end
            for (int j = 0; j < ROW_SIZE; j++) begin
                total++; if (o_letters[r][j] !== exp_l[r][j]) begin bad++;
                    $display("FAIL reset_slot [%0d][%0d] got=%0d want=%0d", r, j, o_letters[r][j], exp_l[r][j]); end
            end
        end
    endtask

    task automatic test_basic;
        do_reset();
        send(8'd37); send(8'd10); send(8'd15);
        total++; if (o_letter_cnt[0] !== 4'd0) begin bad++;
            $display("FAIL basic_precommit_cnt got=%0d want=0", o_letter_cnt[0]); end
        frame_pulse();
        clear_exp();
        exp_c[0] = 4'd3; exp_l[0][0] = 8'd37; exp_l[0][1] = 8'd10; exp_l[0][2] = 8'd15;
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== exp_c[r]) begin bad++;
                $display("FAIL basic_cnt row%0d got=%0d want=%0d", r, o_letter_cnt[r], exp_c[r]); end
            for (int j = 0; j < ROW_SIZE; j++) begin
                total++; if (o_letters[r][j] !== exp_l[r][j]) begin bad++;
                    $display("FAIL basic_slot [%0d][%0d] got=%0d want=%0d", r, j, o_letters[r][j], exp_l[r][j]); end
            end
        end
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd3) begin bad++;
            $display("FAIL basic_cursor got=(%0d,%0d) want=(0,3)", o_cursor_row, o_cursor_col); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 1; i <= 11; i++) send(8'(i));
        total++; if (o_letter_cnt[0] !== 4'd0 || o_letter_cnt[1] !== 4'd0 || o_letters[0][0] !== 8'd0) begin bad++;
            $display("FAIL wrap_precommit got cnt0=%0d cnt1=%0d slot00=%0d want 0/0/0",
                     o_letter_cnt[0], o_letter_cnt[1], o_letters[0][0]); end
        frame_pulse();
        clear_exp();
        exp_c[0] = 4'd10; exp_c[1] = 4'd1; exp_l[1][0] = 8'd11;
        for (int j = 0; j < ROW_SIZE; j++) exp_l[0][j] = 8'(j + 1);
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== exp_c[r]) begin bad++;
                $display("FAIL wrap_cnt row%0d got=%0d want=%0d", r, o_letter_cnt[r], exp_c[r]); end
            for (int j = 0; j < ROW_SIZE; j++) begin
                total++; if (o_letters[r][j] !== exp_l[r][j]) begin bad++;
                    $display("FAIL wrap_slot [%0d][%0d] got=%0d want=%0d", r, j, o_letters[r][j], exp_l[r][j]); end
            end
        end
        total++; if (o_cursor_row !== 2'd1 || o_cursor_col !== 4'd1) begin bad++;
            $display("FAIL wrap_cursor got=(%0d,%0d) want=(1,1)", o_cursor_row, o_cursor_col); end
    endtask

    task automatic test_scroll;
        int n;
        do_reset();
        for (int i = 0; i < 30; i++) send(8'(100 + i));
        i_valid = 1'b1; i_code = 8'd22;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_ready && n < 10) begin n++; @(negedge i_clk); end
        total++; if (n != 3) begin bad++; $display("FAIL scroll_busy_cycles got=%0d want=3", n); end
        total++; if (o_cursor_row !== 2'd2 || o_cursor_col !== 4'd1) begin bad++;
            $display("FAIL scroll_cursor got=(%0d,%0d) want=(2,1)", o_cursor_row, o_cursor_col); end
        frame_pulse();
        clear_exp();
        exp_c[0] = 4'd10; exp_c[1] = 4'd10; exp_c[2] = 4'd1; exp_l[2][0] = 8'd22;
        for (int j = 0; j < ROW_SIZE; j++) begin
            exp_l[0][j] = 8'(110 + j);
            exp_l[1][j] = 8'(120 + j);
        end
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== exp_c[r]) begin bad++;
                $display("FAIL scroll_cnt row%0d got=%0d want=%0d", r, o_letter_cnt[r], exp_c[r]); end
            for (int j = 0; j < ROW_SIZE; j++) begin
                total++; if (o_letters[r][j] !== exp_l[r][j]) begin bad++;
                    $display("FAIL scroll_slot [%0d][%0d] got=%0d want=%0d", r, j, o_letters[r][j], exp_l[r][j]); end
            end
        end
    endtask

    task automatic test_backspace;
        do_reset();
        for (int i = 0; i < 10; i++) send(8'(50 + i));
        send(NL_CODE);
        total++; if (o_cursor_row !== 2'd1 || o_cursor_col !== 4'd0) begin bad++;
            $display("FAIL bs_after_nl got=(%0d,%0d) want=(1,0)", o_cursor_row, o_cursor_col); end
        send(BS_CODE);
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd10) begin bad++;
            $display("FAIL bs_row_up got=(%0d,%0d) want=(0,10)", o_cursor_row, o_cursor_col); end
        send(BS_CODE);
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd9) begin bad++;
            $display("FAIL bs_erase got=(%0d,%0d) want=(0,9)", o_cursor_row, o_cursor_col); end
        frame_pulse();
        total++; if (o_letter_cnt[0] !== 4'd9 || o_letters[0][9] !== 8'd0 || o_letters[0][8] !== 8'd58) begin bad++;
            $display("FAIL bs_commit got cnt=%0d s9=%0d s8=%0d want 9/0/58",
                     o_letter_cnt[0], o_letters[0][9], o_letters[0][8]); end
        for (int i = 0; i < 10; i++) send(BS_CODE);
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd0) begin bad++;
            $display("FAIL bs_origin_noop got=(%0d,%0d) want=(0,0)", o_cursor_row, o_cursor_col); end
        frame_pulse();
        total++; if (o_letter_cnt[0] !== 4'd0 || o_letters[0][0] !== 8'd0) begin bad++;
            $display("FAIL bs_all_erased got cnt=%0d s0=%0d want 0/0", o_letter_cnt[0], o_letters[0][0]); end
    endtask

    task automatic test_clear_frame;
        int n;
        do_reset();
        send(8'd5); send(8'd6); send(NL_CODE); send(8'd7);
        frame_pulse();
        total++; if (o_letter_cnt[0] !== 4'd2 || o_letter_cnt[1] !== 4'd1 || o_letters[1][0] !== 8'd7) begin bad++;
            $display("FAIL clr_setup got cnt0=%0d cnt1=%0d s10=%0d want 2/1/7",
                     o_letter_cnt[0], o_letter_cnt[1], o_letters[1][0]); end
        i_valid = 1'b1; i_code = CLR_CODE;
        @(negedge i_clk);
        i_valid = 1'b0; i_frame_start = 1'b1;
        @(negedge i_clk);
        i_frame_start = 1'b0;
        n = 0;
        while (!o_ready && n < 10) begin n++; @(negedge i_clk); end
        total++; if (!o_ready) begin bad++; $display("FAIL clr_ready_timeout got=%b want=1", o_ready); end
        total++; if (o_letter_cnt[0] !== 4'd2) begin bad++;
            $display("FAIL clr_deferred_early got cnt0=%0d want=2", o_letter_cnt[0]); end
        @(negedge i_clk);
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== 4'd0 || o_letters[r][0] !== 8'd0) begin bad++;
                $display("FAIL clr_commit row%0d got cnt=%0d s0=%0d want 0/0", r, o_letter_cnt[r], o_letters[r][0]); end
        end
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd0) begin bad++;
            $display("FAIL clr_cursor got=(%0d,%0d) want=(0,0)", o_cursor_row, o_cursor_col); end
        send(8'd9);
        repeat (3) @(negedge i_clk);
        total++; if (o_letter_cnt[0] !== 4'd0) begin bad++;
            $display("FAIL clr_second_commit got cnt0=%0d want=0", o_letter_cnt[0]); end
        frame_pulse();
        total++; if (o_letter_cnt[0] !== 4'd1 || o_letters[0][0] !== 8'd9) begin bad++;
            $display("FAIL clr_after got cnt0=%0d s0=%0d want 1/9", o_letter_cnt[0], o_letters[0][0]); end
    endtask

    task automatic test_reset_scroll;
        do_reset();
        for (int i = 0; i < 30; i++) send(8'(100 + i));
        frame_pulse();
        total++; if (o_letter_cnt[2] !== 4'd10 || o_letters[2][9] !== 8'd129) begin bad++;
            $display("FAIL rst_setup got cnt2=%0d s29=%0d want 10/129", o_letter_cnt[2], o_letters[2][9]); end
        i_valid = 1'b1; i_code = 8'd55;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_in_scroll got ready=%b want=0", o_ready); end
        i_rst = 1'b1;
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b want=1", o_ready); end
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== 4'd0) begin bad++;
                $display("FAIL rst_async_cnt row%0d got=%0d want=0", r, o_letter_cnt[r]); end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        frame_pulse();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", o_ready); end
        total++; if (o_cursor_row !== 2'd0 || o_cursor_col !== 4'd0) begin bad++;
            $display("FAIL rst_cursor got=(%0d,%0d) want=(0,0)", o_cursor_row, o_cursor_col); end
        for (int r = 0; r < ROW_CNT; r++) begin
            total++; if (o_letter_cnt[r] !== 4'd0) begin bad++;
                $display("FAIL rst_cnt row%0d got=%0d want=0", r, o_letter_cnt[r]); end
            for (int j = 0; j < ROW_SIZE; j++) begin
                total++; if (o_letters[r][j] !== 8'd0) begin bad++;
                    $display("FAIL rst_slot [%0d][%0d] got=%0d want=0", r, j, o_letters[r][j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_scroll();
        test_backspace();
        test_clear_frame();
        test_reset_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_text_buffer.md
Name: vga_text_buffer

Overview:
- Writer side of the VGA text display: owns the ROW_CNT x ROW_SIZE letter grid and per-row letter counts that the VGA display/color path reads every pixel.
- Accepts one glyph/control code per valid/ready handshake from the gesture recognizer and edits a working buffer: append, auto-wrap, newline, backspace, clear, scroll.
- Copies the working buffer to the display-facing registers only at frame boundaries, so the screen never tears mid-frame.

Parameters:
- ROW_CNT, 3, number of text rows
- ROW_SIZE, 10, letter slots per row (letter count width is 4 bits)
- BLANK_CODE, 8'd0, code written into empty slots
- BS_CODE, 8'hF0, backspace control code
- NL_CODE, 8'hF1, newline control code
- CLR_CODE, 8'hF2, clear-screen control code

Ports:
- i_clk  in  1  pixel/system clock (25 MHz)
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  code present on i_code
- i_code  in  8  glyph pattern number or control code
- o_ready  out  1  block can accept a code this cycle
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- o_letter_cnt  out  4 x [0:ROW_CNT-1]  committed letters per row
- o_letters  out  8 x [0:ROW_CNT-1][0:ROW_SIZE-1]  committed glyph codes
- o_cursor_row  out  2  working cursor row
- o_cursor_col  out  4  working cursor column (= working count of cursor row)

Behaviour:
- Reset: all working and committed slots are BLANK_CODE, all counts are 0, cursor is (0,0), state is S_IDLE, commit_pending is 0, o_ready is 1.
- Handshake: o_ready = (state == S_IDLE). A code is accepted on a rising edge with i_valid && o_ready. The working buffer updates at that edge.
- Printable code (any code not BS/NL/CLR), with the cursor row holding c letters:
  - c < ROW_SIZE: write slot [row][c]; count becomes c+1.
  - c == ROW_SIZE and row < ROW_CNT-1: cursor moves to row+1; write slot [row+1][0]; count becomes 1.
  - c == ROW_SIZE and row == ROW_CNT-1: hold the code and enter S_SCROLL.
- NL_CODE:
  - row < ROW_CNT-1: cursor row increments. Rows below the cursor are always empty.
  - Last row: enter S_SCROLL with no held code.
- BS_CODE:
  - c > 0: count becomes c-1; slot [row][c-1] becomes BLANK_CODE.
  - c == 0 and row > 0: cursor row decrements; nothing is erased.
  - Cursor at (0,0): no-op.
- CLR_CODE: enter S_CLEAR.
- S_SCROLL lasts ROW_CNT cycles, o_ready = 0:
  - Cycle k (0..ROW_CNT-2): copy row k+1 (slots and count) into row k.
  - Final cycle: blank the last row. If a printable code is held, write it at [ROW_CNT-1][0] with count 1; otherwise count is 0.
  - Then return to S_IDLE with the cursor on the last row.
- S_CLEAR lasts ROW_CNT cycles, o_ready = 0: cycle k blanks row k and zeroes its count. The cursor is (0,0) on exit to S_IDLE.
- Commit:
  - commit_pending is set by i_frame_start.
  - In any S_IDLE cycle with (commit_pending || i_frame_start), all committed registers load the pre-edge working values and commit_pending clears.
  - If a code is accepted in the same cycle, its edit is not in this commit; it appears at the next frame.
  - A frame_start during S_SCROLL/S_CLEAR is deferred to the first S_IDLE cycle. Multiple deferred frame_starts collapse into one commit.
- Latency: an accepted code appears on o_letters no earlier than the edge after the next commit cycle. o_cursor_* reflect the working state with 1-cycle latency.
- Reset asserted mid-scroll or mid-clear aborts the operation, discards any held code, and returns to the reset state.
- Control codes never occupy a slot. Counts never exceed ROW_SIZE.

Decomposition:
- Shared package vga_text_pkg holds:
  - ROW_CNT and ROW_SIZE (replacing per-file defines)
  - BLANK/BS/NL/CLR code constants
  - state enum {S_IDLE, S_SCROLL, S_CLEAR}
  - a row-index counter width constant
- Single module, no sub-module. The row copy/blank is a simple per-row mux; splitting it out adds no value.

Test Plan:
- Reset, then send codes 37,10,15 and pulse i_frame_start -> o_letter_cnt[0]=3; o_letters[0][0..2]=37,10,15; all other slots 0.
- Send 11 printable codes with no frame_start, then pulse frame_start -> committed outputs stay all-zero until the commit; afterwards row0 cnt=10, row1 cnt=1, row1[0]=11th code, cursor (1,1).
- Fill all 30 slots, then send code 22 -> o_ready low exactly 3 cycles; after commit, old row1 is in row0, old row2 is in row1, row2 cnt=1 with row2[0]=22, cursor (2,1).
- Cursor at (1,0) with row0 full, send BS twice -> cursor goes to (0,10), then (0,9) with row0[9]=0; a further BS at (0,0) is a no-op.
- Pulse i_frame_start during a CLR (S_CLEAR) -> commit happens on the first S_IDLE cycle; all counts are 0 after it and no second commit occurs.
- Assert i_rst on the 2nd S_SCROLL cycle -> all outputs return to reset values, the held code never appears, and o_ready=1 after release.
